// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//   Owns one port of a single-clock simple dual-port RAM. After reset it can
//   fill the whole RAM with CLEAR_VAL. It then shares the port round-robin
//   between NREQ requesters, with at most one RAM access per clock.
//
// Ports
//   clk, reset          : clock and asynchronous active-high reset
//   req/we/addr/wdata   : per-requester request level, write strobe, packed
//                         address and write data (requester i uses slice i)
//   gnt                 : one-hot pulse, request accepted (1 cycle after req)
//   rvalid              : one-hot pulse, rdata valid (1 cycle after gnt)
//   rdata               : shared return data, a pass-through of ram_q
//   busy                : high while the clear sweep runs
//   ram_we/addr/d/q     : RAM port, where q is registered with write-first behaviour
module dpram_port_arbiter #(
  parameter int                aWidth         = 10,
  parameter int                dWidth         = 8,
  parameter int                NREQ           = 3,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [dWidth-1:0] CLEAR_VAL      = {dWidth{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*aWidth-1:0] addr,
  input  logic [NREQ*dWidth-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [dWidth-1:0]      rdata,
  output logic                   busy,
  output logic                   ram_we,
  output logic [aWidth-1:0]      ram_addr,
  output logic [dWidth-1:0]      ram_d,
  input  logic [dWidth-1:0]      ram_q
);

  localparam int                PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [aWidth-1:0] LAST_ADDR = {aWidth{1'b1}};
  localparam logic [aWidth-1:0] ONE_A     = {{(aWidth-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0]   ONE_N     = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]     LAST_REQ  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [aWidth-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;
  logic                busy_q, busy_d;
  logic                ram_we_q, ram_we_d;
  logic [aWidth-1:0]   ram_addr_q, ram_addr_d;
  logic [dWidth-1:0]   ram_d_q, ram_d_d;

  logic [NREQ-1:0]     eligible_s;
  logic                found_s;
  logic [PW-1:0]       win_s;

  // Circular first-eligible search starting at the round-robin pointer.
  // A requester that holds gnt this cycle is masked so that one request
  // produces exactly one grant.
  always_comb begin : arb_search
    int            sum_v;
    logic [PW-1:0] idx_v;
    eligible_s = req & ~gnt_q;
    found_s    = 1'b0;
    win_s      = {PW{1'b0}};
    sum_v      = 0;
    idx_v      = {PW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum_v   = int'(rr_q) + k;
      idx_v   = (sum_v >= NREQ) ? PW'(sum_v - NREQ) : PW'(sum_v);
      win_s   = (eligible_s[idx_v] && !found_s) ? idx_v : win_s;
      found_s = found_s | eligible_s[idx_v];
    end
  end

  // Next-state and next-output logic for the RST/CLEAR/RUN sequencer.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    gnt_d      = {NREQ{1'b0}};
    rvalid_d   = gnt_q;
    busy_d     = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_d_d    = ram_d_q;
    case (state_q)
      ST_RST: begin
        if (CLEAR_ON_RESET != 0) begin
          state_d    = ST_CLEAR;
          busy_d     = 1'b1;
          ram_we_d   = 1'b1;
          cnt_d      = {aWidth{1'b0}};
          ram_addr_d = {aWidth{1'b0}};
          ram_d_d    = CLEAR_VAL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: begin
        // cnt_q is the address being written in this cycle.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          busy_d     = 1'b1;
          ram_we_d   = 1'b1;
          cnt_d      = cnt_q + ONE_A;
          ram_addr_d = cnt_q + ONE_A;
          ram_d_d    = CLEAR_VAL;
        end
      end
      ST_RUN: begin
        if (found_s) begin
          gnt_d      = ONE_N << win_s;
          ram_we_d   = we[win_s];
          ram_addr_d = addr[win_s*aWidth +: aWidth];
          ram_d_d    = wdata[win_s*dWidth +: dWidth];
          rr_d       = (win_s == LAST_REQ) ? {PW{1'b0}} : win_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
          gnt_d = {NREQ{1'b0}};
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // State and registered outputs. Reset aborts any sweep or in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RST;
      rr_q       <= {PW{1'b0}};
      cnt_q      <= {aWidth{1'b0}};
      gnt_q      <= {NREQ{1'b0}};
      rvalid_q   <= {NREQ{1'b0}};
      busy_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= {aWidth{1'b0}};
      ram_d_q    <= {dWidth{1'b0}};
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      busy_q     <= busy_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_d_q    <= ram_d_d;
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign busy     = busy_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_d    = ram_d_q;
  assign rdata    = ram_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed testbench for dpram_port_arbiter.
//   u_dut_a : aWidth=4, CLEAR_ON_RESET=1, CLEAR_VAL=8'hA5 (sweep, reset mid-sweep)
//   u_dut_b : aWidth=10, CLEAR_ON_RESET=0 (no-clear start, contention, single
//             access, masking)
// Each instance has a write-first registered RAM model on its port.
module tb_dpram_port_arbiter;
  localparam int AW_A = 4;
  localparam int AW_B = 10;
  localparam int DW   = 8;
  localparam int NR   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_a, rst_b;
  logic [NR-1:0]        req_a, we_a, gnt_a, rvalid_a;
  logic [NR-1:0]        req_b, we_b, gnt_b, rvalid_b;
  logic [NR*AW_A-1:0]   addr_a;
  logic [NR*AW_B-1:0]   addr_b;
  logic [NR*DW-1:0]     wdata_a, wdata_b;
  logic [DW-1:0]        rdata_a, rdata_b, ram_d_a, ram_d_b, ram_q_a, ram_q_b;
  logic                 busy_a, busy_b, ram_we_a, ram_we_b;
  logic [AW_A-1:0]      ram_addr_a;
  logic [AW_B-1:0]      ram_addr_b;

  logic [DW-1:0] mem_a [0:(1<<AW_A)-1];
  logic [DW-1:0] mem_b [0:(1<<AW_B)-1];

  int n_checks = 0;
  int n_errors = 0;
  int cnt_g, cnt_v;
  logic [NR-1:0] exp_g [0:5];

  dpram_port_arbiter #(.aWidth(AW_A), .dWidth(DW), .NREQ(NR),
                       .CLEAR_ON_RESET(1), .CLEAR_VAL(8'hA5)) u_dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .busy(busy_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_d(ram_d_a), .ram_q(ram_q_a));

  dpram_port_arbiter #(.aWidth(AW_B), .dWidth(DW), .NREQ(NR),
                       .CLEAR_ON_RESET(0), .CLEAR_VAL(8'h00)) u_dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
    .busy(busy_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_d(ram_d_b), .ram_q(ram_q_b));

  // RAM model for instance A: registered read, write returns written data.
  always @(posedge clk) begin
    if (ram_we_a) begin
      mem_a[ram_addr_a] <= ram_d_a;
      ram_q_a           <= ram_d_a;
    end else begin
      ram_q_a <= mem_a[ram_addr_a];
    end
  end

  // RAM model for instance B.
  always @(posedge clk) begin
    if (ram_we_b) begin
      mem_b[ram_addr_b] <= ram_d_b;
      ram_q_b           <= ram_d_b;
    end else begin
      ram_q_b <= mem_b[ram_addr_b];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 3'b000; we_a = 3'b000; addr_a = '0; wdata_a = '0;
    req_b = 3'b000; we_b = 3'b000; addr_b = '0; wdata_b = '0;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
    repeat (2) tick;

    // Reset state
    check("rst_busy",   32'(busy_a),     32'd0);
    check("rst_gnt",    32'(gnt_a),      32'd0);
    check("rst_rvalid", 32'(rvalid_a),   32'd0);
    check("rst_ram_we", 32'(ram_we_a),   32'd0);
    check("rst_addr",   32'(ram_addr_a), 32'd0);
    check("rst_d",      32'(ram_d_a),    32'd0);
    check("rst_gnt_b",  32'(gnt_b),      32'd0);

    // Clear sweep; req0 (read addr 7) is raised during the sweep and must wait
    addr_a[0 +: AW_A] = 4'd7;
    req_a = 3'b001;
    rst_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      check("sweep_busy", 32'(busy_a),     32'd1);
      check("sweep_we",   32'(ram_we_a),   32'd1);
      check("sweep_addr", 32'(ram_addr_a), 32'(i));
      check("sweep_d",    32'(ram_d_a),    32'hA5);
      check("sweep_gnt",  32'(gnt_a),      32'd0);
    end
    tick;
    check("sweep_end_busy", 32'(busy_a),   32'd0);
    check("sweep_end_we",   32'(ram_we_a), 32'd0);
    check("sweep_end_gnt",  32'(gnt_a),    32'd0);
    tick;
    check("clr_rd_gnt",  32'(gnt_a),      32'b001);
    check("clr_rd_addr", 32'(ram_addr_a), 32'd7);
    check("clr_rd_we",   32'(ram_we_a),   32'd0);
    req_a = 3'b000;
    tick;
    check("clr_rd_rvalid", 32'(rvalid_a), 32'b001);
    check("clr_rd_data",   32'(rdata_a),  32'hA5);
    check("clr_rd_gnt0",   32'(gnt_a),    32'd0);

    // Reset mid-sweep at address 9, then a full restart from 0
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    check("mid_addr", 32'(ram_addr_a), 32'd9);
    rst_a = 1'b1;
    #1;
    check("abort_busy",   32'(busy_a),     32'd0);
    check("abort_we",     32'(ram_we_a),   32'd0);
    check("abort_addr",   32'(ram_addr_a), 32'd0);
    check("abort_d",      32'(ram_d_a),    32'd0);
    check("abort_gnt",    32'(gnt_a),      32'd0);
    check("abort_rvalid", 32'(rvalid_a),   32'd0);
    tick;
    tick;
    rst_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      check("resweep_busy", 32'(busy_a),     32'd1);
      check("resweep_addr", 32'(ram_addr_a), 32'(i));
    end
    tick;
    check("resweep_end_busy", 32'(busy_a), 32'd0);

    // No clear: req2 asserted during reset is granted in the 2nd cycle after release
    addr_b[2*AW_B +: AW_B] = 10'h055;
    req_b = 3'b100;
    rst_b = 1'b0;
    tick;
    check("nclr_gnt_early", 32'(gnt_b),  32'd0);
    check("nclr_busy1",     32'(busy_b), 32'd0);
    tick;
    check("nclr_gnt",   32'(gnt_b),  32'b100);
    check("nclr_busy2", 32'(busy_b), 32'd0);
    req_b = 3'b000;
    tick;
    check("nclr_rvalid", 32'(rvalid_b), 32'b100);
    check("nclr_gnt0",   32'(gnt_b),    32'd0);

    // Contention: all three held high, grants rotate 0,1,2,0,1,2
    addr_b[0 +: AW_B]      = 10'h100;
    addr_b[AW_B +: AW_B]   = 10'h101;
    addr_b[2*AW_B +: AW_B] = 10'h102;
    req_b = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick;
      check("cont_gnt",    32'(gnt_b),    32'(exp_g[k]));
      check("cont_rvalid", 32'(rvalid_b), (k == 0) ? 32'd0 : 32'(exp_g[k-1]));
    end
    req_b = 3'b000;
    tick;
    check("cont_end_gnt",    32'(gnt_b),    32'd0);
    check("cont_end_rvalid", 32'(rvalid_b), 32'b100);

    // Single access: write 8'h3C to 0x012, then read it back
    addr_b[0 +: AW_B] = 10'h012;
    wdata_b[0 +: DW]  = 8'h3C;
    we_b  = 3'b001;
    req_b = 3'b001;
    tick;
    check("wr_gnt",    32'(gnt_b),      32'b001);
    check("wr_we",     32'(ram_we_b),   32'd1);
    check("wr_addr",   32'(ram_addr_b), 32'h012);
    check("wr_d",      32'(ram_d_b),    32'h3C);
    check("wr_rvalid", 32'(rvalid_b),   32'd0);
    we_b = 3'b000;
    tick;
    check("wr_gnt_masked", 32'(gnt_b),    32'd0);
    check("wr_rvalid1",    32'(rvalid_b), 32'b001);
    check("wr_rdata",      32'(rdata_b),  32'h3C);
    tick;
    check("rd_gnt",  32'(gnt_b),      32'b001);
    check("rd_we",   32'(ram_we_b),   32'd0);
    check("rd_addr", 32'(ram_addr_b), 32'h012);
    req_b = 3'b000;
    tick;
    check("rd_rvalid", 32'(rvalid_b), 32'b001);
    check("rd_rdata",  32'(rdata_b),  32'h3C);

    // Masking: req1 alone held for 6 cycles gives 3 alternating grants
    addr_b[AW_B +: AW_B] = 10'h012;
    req_b = 3'b010;
    cnt_g = 0;
    cnt_v = 0;
    for (int k = 0; k < 7; k++) begin
      tick;
      if (k == 5) req_b = 3'b000;
      check("mask_gnt",    32'(gnt_b),    (k < 6 && (k % 2) == 0) ? 32'b010 : 32'd0);
      check("mask_rvalid", 32'(rvalid_b), ((k % 2) == 1) ? 32'b010 : 32'd0);
      if (rvalid_b[1]) check("mask_rdata", 32'(rdata_b), 32'h3C);
      cnt_g = cnt_g + int'(gnt_b[1]);
      cnt_v = cnt_v + int'(rvalid_b[1]);
    end
    check("mask_gnt_count",    32'(cnt_g), 32'd3);
    check("mask_rvalid_count", 32'(cnt_v), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
